// File: rtl/cp0_exc_sequencer.sv
// Arbitrates exception entry, ERET and MTC0/MFC0 requests onto CP0's one-hot strobes,
// issues the PC redirect and tracks exception nesting depth.
module cp0_exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
  parameter int          MAX_DEPTH  = 6
) (
  input  logic        cp0_clk,
  input  logic        cp0_rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        eret_valid,
  input  logic        acc_valid,
  input  logic        acc_write,
  input  logic [4:0]  acc_sel,
  input  logic [31:0] acc_wdata,
  input  logic [31:0] epc_in,
  output logic        ack,
  output logic        stall,
  output logic        cp0_ena,
  output logic        cp0_mfc0,
  output logic        cp0_mtc0,
  output logic        cp0_eret,
  output logic [31:0] cp0_addr,
  output logic [4:0]  cp0_cause,
  output logic [31:0] cp0_pc,
  output logic [31:0] cp0_data,
  output logic        rdata_valid,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [2:0]  depth,
  output logic        err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] EXC_SAVE  = 3'd1;
  localparam logic [2:0] EXC_JUMP  = 3'd2;
  localparam logic [2:0] ERET_RD   = 3'd3;
  localparam logic [2:0] ERET_JUMP = 3'd4;
  localparam logic [2:0] ACC       = 3'd5;

  localparam logic [2:0] DEPTH_LIMIT = 3'(MAX_DEPTH);

  logic [2:0]  state_reg, state_next;
  logic [2:0]  depth_reg;
  logic [4:0]  code_reg;
  logic [31:0] pc_reg;
  logic [31:0] epc_reg;
  logic        write_reg;
  logic [4:0]  sel_reg;
  logic [31:0] wdata_reg;

  logic idle, code_ok;
  logic grant_exc, grant_eret, grant_acc;
  logic reject_exc, reject_eret;

  // Reset is folded into idle so ack/err stay low while cp0_rst is held.
  assign idle    = (state_reg == IDLE) && !cp0_rst;
  assign code_ok = (exc_code == 5'd8) || (exc_code == 5'd9) || (exc_code == 5'd13);

  assign grant_exc   = idle && exc_valid && code_ok && (depth_reg != DEPTH_LIMIT);
  assign reject_exc  = idle && exc_valid && !(code_ok && (depth_reg != DEPTH_LIMIT));
  assign grant_eret  = idle && !exc_valid && eret_valid && (depth_reg != 3'd0);
  assign reject_eret = idle && !exc_valid && eret_valid && (depth_reg == 3'd0);
  assign grant_acc   = idle && !exc_valid && !eret_valid && acc_valid;

  assign ack = grant_exc || grant_eret || grant_acc;
  assign err = reject_exc || reject_eret;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_exc)       state_next = EXC_SAVE;
        else if (grant_eret) state_next = ERET_RD;
        else if (grant_acc)  state_next = ACC;
      end
      EXC_SAVE:  state_next = EXC_JUMP;
      EXC_JUMP:  state_next = IDLE;
      ERET_RD:   state_next = ERET_JUMP;
      ERET_JUMP: state_next = IDLE;
      ACC:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge cp0_clk or posedge cp0_rst) begin
    if (cp0_rst) begin
      state_reg <= IDLE;
      depth_reg <= 3'd0;
      code_reg  <= 5'd0;
      pc_reg    <= 32'd0;
      epc_reg   <= 32'd0;
      write_reg <= 1'b0;
      sel_reg   <= 5'd0;
      wdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (grant_exc) begin
        code_reg <= exc_code;
        pc_reg   <= exc_pc;
      end
      if (grant_acc) begin
        write_reg <= acc_write;
        sel_reg   <= acc_sel;
        wdata_reg <= acc_wdata;
      end
      if (state_reg == EXC_SAVE) depth_reg <= depth_reg + 3'd1;
      // CP0 has already popped STATUS at the falling edge; EPC is stable here.
      if (state_reg == ERET_RD) begin
        depth_reg <= depth_reg - 3'd1;
        epc_reg   <= epc_in;
      end
    end
  end

  always_comb begin
    cp0_ena     = cp0_rst;
    cp0_mfc0    = 1'b0;
    cp0_mtc0    = 1'b0;
    cp0_eret    = 1'b0;
    cp0_addr    = 32'd0;
    cp0_cause   = 5'd0;
    cp0_pc      = 32'd0;
    cp0_data    = 32'd0;
    rdata_valid = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    case (state_reg)
      EXC_SAVE: begin
        cp0_ena   = 1'b1;
        cp0_cause = code_reg;
        cp0_pc    = pc_reg;
      end
      EXC_JUMP: begin
        redirect    = 1'b1;
        redirect_pc = EXC_VECTOR;
      end
      ERET_RD: begin
        cp0_ena  = 1'b1;
        cp0_eret = 1'b1;
      end
      ERET_JUMP: begin
        redirect    = 1'b1;
        redirect_pc = epc_reg;
      end
      ACC: begin
        cp0_ena     = 1'b1;
        cp0_mtc0    = write_reg;
        cp0_mfc0    = !write_reg;
        cp0_addr    = {27'd0, sel_reg};
        cp0_data    = wdata_reg;
        rdata_valid = !write_reg;
      end
      default: ;
    endcase
  end

  assign stall = (state_reg != IDLE);
  assign depth = depth_reg;

endmodule
